// File: rtl/risc_loader_pkg.sv
// risc_loader_pkg: shared definitions for the RISC program loader.
//   - command opcode encoding (top two bits of a command word)
//   - loader FSM state enum
//   - field-width constants; the count field is whatever DW leaves after OP_W
package risc_loader_pkg;

  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] OP_LOAD_INSTR  = 2'b00;
  localparam logic [OP_W-1:0] OP_LOAD_DATA   = 2'b01;
  localparam logic [OP_W-1:0] OP_RUN         = 2'b10;
  localparam logic [OP_W-1:0] OP_CLEAR_FLAGS = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LOAD, S_CLR, S_RUN, S_DONE
  } state_e;

  // Width of the count field for a given word width.
  function automatic int cnt_width(input int dw);
    return dw - OP_W;
  endfunction

  // Both LOAD opcodes have a zero MSB; bit 0 selects the data port.
  function automatic logic is_load(input logic [OP_W-1:0] op);
    return !op[OP_W-1];
  endfunction

endpackage

// File: rtl/risc_prog_loader_if.sv
// risc_prog_loader_if: the two streaming channels of the loader.
//   in_valid/in_ready/in_data    : command stream into the loader
//   out_valid/out_ready/out_data : captured OUT values leaving the loader
// master = stream producer/consumer outside the loader, slave = the loader.
interface risc_prog_loader_if #(
  parameter int DW = 16
) ();
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/risc_out_fifo.sv
// risc_out_fifo: synchronous FIFO for captured OUT values.
//   clk_i, rst_ni (async, active low)
//   push_i/push_data_i : write; ignored when full unless popping the same cycle
//   pop_i              : read-advance; ignored when empty
//   rd_data_o          : head entry, driven from storage (no fall-through)
//   full_o, empty_o    : status
// DEPTH must be a power of two, at least 2.
module risc_out_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] rd_data_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW:0]   wr_q, rd_q;   // extra MSB distinguishes full from empty
  logic          wr_en, rd_en;

  assign empty_o   = (wr_q == rd_q);
  assign full_o    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  // When full, a same-cycle pop frees the head slot that the push lands in.
  assign wr_en     = push_i && (!full_o || pop_i);
  assign rd_en     = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_q[PW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q[PW-1:0]] <= push_data_i;
  end
endmodule

// File: rtl/risc_prog_loader.sv
// risc_prog_loader: load-and-run controller for the single-cycle RISC core.
//   clk, clr_n (async, active low)
//   bus.slave        : command stream in, captured OUT stream out
//   test_normal      : 1 = loader owns memories, 0 = core runs
//   ext_instr_*      : instruction memory write port (registered)
//   ext_data_*       : data memory write port (registered)
//   cpu_clr          : core clear pulse (the single CLR cycle)
//   cpu_out/_valid   : core OUT strobe, captured during CLR/RUN
//   cpu_halt         : core halted, only looked at in RUN
//   busy/run_done/timeout/ovf : status (last three sticky)
// Macro PROG_LOADER_TIMEOUT_EN adds a TMO_W-bit RUN watchdog; without it RUN
// waits for cpu_halt forever and timeout is 0. AW must not exceed DW.
module risc_prog_loader
  import risc_loader_pkg::*;
#(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int OUT_DEPTH = 8,
  parameter int TMO_W     = 16
) (
  input  logic              clk,
  input  logic              clr_n,
  risc_prog_loader_if.slave bus,
  output logic              test_normal,
  output logic              ext_instr_we,
  output logic [AW-1:0]     ext_instr_addr,
  output logic [DW-1:0]     ext_instr_data,
  output logic              ext_data_we,
  output logic [AW-1:0]     ext_data_addr,
  output logic [DW-1:0]     ext_data_data,
  output logic              cpu_clr,
  input  logic [DW-1:0]     cpu_out,
  input  logic              cpu_out_valid,
  input  logic              cpu_halt,
  output logic              busy,
  output logic              run_done,
  output logic              timeout,
  output logic              ovf
);
  localparam int CNT_W = cnt_width(DW);

  state_e           state_q, state_d;
  logic             sel_data_q, sel_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             iwe_q, iwe_d, dwe_q, dwe_d;
  logic [AW-1:0]    iaddr_q, iaddr_d, daddr_q, daddr_d;
  logic [DW-1:0]    idata_q, idata_d, ddata_q, ddata_d;
  logic             run_done_q, run_done_d, ovf_q, ovf_d;
  logic             in_hs, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [OP_W-1:0]  op;
  logic [CNT_W-1:0] cmd_cnt;

`ifdef PROG_LOADER_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_flag_q, tmo_flag_d;
  assign timeout = tmo_flag_q;
`else
  assign timeout = 1'b0;
`endif

  assign op      = bus.in_data[DW-1 -: OP_W];
  assign cmd_cnt = bus.in_data[CNT_W-1:0];

  assign bus.in_ready = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_LOAD);
  assign in_hs        = bus.in_valid && bus.in_ready;
  assign test_normal  = !((state_q == S_CLR) || (state_q == S_RUN));
  assign cpu_clr      = (state_q == S_CLR);
  assign busy         = (state_q != S_IDLE);
  assign run_done     = run_done_q;
  assign ovf          = ovf_q;

  assign ext_instr_we   = iwe_q;
  assign ext_instr_addr = iaddr_q;
  assign ext_instr_data = idata_q;
  assign ext_data_we    = dwe_q;
  assign ext_data_addr  = daddr_q;
  assign ext_data_data  = ddata_q;

  // OUT capture also covers CLR so a strobe right after release is not lost.
  assign fifo_push     = cpu_out_valid && ((state_q == S_CLR) || (state_q == S_RUN));
  assign fifo_pop      = bus.out_valid && bus.out_ready;
  assign bus.out_valid = !fifo_empty;

  risc_out_fifo #(.DW(DW), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk_i       (clk),
    .rst_ni      (clr_n),
    .push_i      (fifo_push),
    .push_data_i (cpu_out),
    .pop_i       (fifo_pop),
    .rd_data_o   (bus.out_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    sel_data_d = sel_data_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    iwe_d      = 1'b0;
    dwe_d      = 1'b0;
    iaddr_d    = iaddr_q;
    idata_d    = idata_q;
    daddr_d    = daddr_q;
    ddata_d    = ddata_q;
    run_done_d = run_done_q;
    ovf_d      = ovf_q;
`ifdef PROG_LOADER_TIMEOUT_EN
    tmo_d      = tmo_q;
    tmo_flag_d = tmo_flag_q;
`endif
    case (state_q)
      S_IDLE: if (in_hs) begin
        if (is_load(op)) begin
          sel_data_d = op[0];
          cnt_d      = cmd_cnt;
          state_d    = S_ADDR;
        end else if (op == OP_RUN) begin
          run_done_d = 1'b0;
`ifdef PROG_LOADER_TIMEOUT_EN
          tmo_flag_d = 1'b0;
`endif
          state_d    = S_CLR;
        end else begin
          run_done_d = 1'b0;
          ovf_d      = 1'b0;
`ifdef PROG_LOADER_TIMEOUT_EN
          tmo_flag_d = 1'b0;
`endif
        end
      end
      S_ADDR: if (in_hs) begin
        addr_d  = bus.in_data[AW-1:0];
        state_d = (cnt_q == '0) ? S_IDLE : S_LOAD;
      end
      S_LOAD: if (in_hs) begin
        if (sel_data_q) begin
          dwe_d   = 1'b1;
          daddr_d = addr_q;
          ddata_d = bus.in_data;
        end else begin
          iwe_d   = 1'b1;
          iaddr_d = addr_q;
          idata_d = bus.in_data;
        end
        addr_d = addr_q + 1'b1;   // wraps modulo 2^AW
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
      end
      S_CLR: begin
`ifdef PROG_LOADER_TIMEOUT_EN
        tmo_d = '0;
`endif
        state_d = S_RUN;
      end
      S_RUN: begin
        if (cpu_halt) begin
          run_done_d = 1'b1;
          state_d    = S_DONE;
        end
`ifdef PROG_LOADER_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + 1'b1;
          // Leaves RUN on the edge where the counter reaches all-ones.
          if (&tmo_d) begin
            tmo_flag_d = 1'b1;
            state_d    = S_DONE;
          end
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= S_IDLE;
      sel_data_q <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      iwe_q      <= 1'b0;
      dwe_q      <= 1'b0;
      iaddr_q    <= '0;
      idata_q    <= '0;
      daddr_q    <= '0;
      ddata_q    <= '0;
      run_done_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_data_q <= sel_data_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      iwe_q      <= iwe_d;
      dwe_q      <= dwe_d;
      iaddr_q    <= iaddr_d;
      idata_q    <= idata_d;
      daddr_q    <= daddr_d;
      ddata_q    <= ddata_d;
      run_done_q <= run_done_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef PROG_LOADER_TIMEOUT_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tmo_q      <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_q      <= tmo_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end
`endif
endmodule

// File: doc/risc_prog_loader.md
# risc_prog_loader

Parametrised load-and-run controller for the single-cycle RISC core. It takes a valid/ready command stream and writes program and data images into the core's external instruction and data memory ports. It then releases the core, clears it, and captures every OUT value into an output FIFO until the core halts. It replaces hand-driven memory writes and OUT monitoring with one streaming, self-checking front end.

## Interface
- AW, 16, memory address width
- DW, 16, word width of memories, command stream and OUT values
- OUT_DEPTH, 8, output FIFO depth (power of two, at least 2)
- TMO_W, 16, run watchdog counter width
- clk  in  1  system clock, rising edge
- clr_n  in  1  asynchronous active-low reset
- in_valid / in_ready / in_data  in/out/in  1/1/DW  command stream
- test_normal  out  1  1 = load mode (external ports own memories), 0 = core runs
- ext_instr_we, ext_instr_addr, ext_instr_data  out  1/AW/DW  instruction memory write port
- ext_data_we, ext_data_addr, ext_data_data  out  1/AW/DW  data memory write port
- cpu_clr  out  1  active-high core clear pulse
- cpu_out  in  DW  core OutR
- cpu_out_valid  in  1  one-cycle strobe per executed OUT
- cpu_halt  in  1  core has executed HLT (level)
- out_valid / out_ready / out_data  out/in/out  1/1/DW  captured OUT values
- busy  out  1  state is not IDLE
- run_done  out  1  sticky, run ended by halt
- timeout  out  1  sticky, run ended by watchdog
- ovf  out  1  sticky, OUT value dropped because the FIFO was full

## Operation
- Command word: op = in_data[DW-1:DW-2], cnt = in_data[DW-3:0].
- op values: 00 LOAD_INSTR, 01 LOAD_DATA, 10 RUN, 11 CLEAR_FLAGS.
- A LOAD command is followed by one base-address word (low AW bits used), then cnt data words.
- Data word k is written to base+k, modulo 2^AW (the address wraps).
- cnt = 0: the address word is consumed, no writes occur, return to IDLE.
- States:
  - IDLE: accept a command.
  - ADDR: accept the base-address word.
  - LOAD: accept data words, decrement the remaining count, go to IDLE after the last word.
  - CLR: one cycle. test_normal = 0, cpu_clr = 1. Go to RUN.
  - RUN: wait for cpu_halt, or for the watchdog when it is compiled in.
  - DONE: set run_done or timeout, test_normal returns to 1, go to IDLE.
- RUN clears run_done and timeout on entry. CLEAR_FLAGS clears run_done, timeout and ovf, and stays in IDLE.
- OUT capture: in RUN (and CLR), cpu_out_valid pushes cpu_out into the FIFO.
  - FIFO full and no pop in the same cycle: the value is dropped and ovf is set.
  - FIFO full with a pop in the same cycle: the push is accepted.
- cpu_out_valid and cpu_halt in the same cycle: the value is captured, then DONE.
- The FIFO drains via out_valid/out_ready in every state.

## Timing
- in_ready = 1 in IDLE, ADDR and LOAD; 0 in CLR, RUN and DONE.
- ext_*_we, addr and data are registered one cycle after the data-word handshake; we pulses one cycle per word.
- Back-to-back writes occur at one word per cycle.
- A RUN handshake is followed by CLR on the next cycle.
- cpu_halt is sampled only in RUN. A halt held from a previous run is ignored during CLR.
- FIFO: a push becomes visible on out_data/out_valid on the next cycle; there is no fall-through.
- Reset values:
  - State IDLE, test_normal = 1, cpu_clr = 0, all we = 0, addr/data = 0.
  - FIFO empty, out_valid = 0; busy, run_done, timeout and ovf all 0.
- Reset mid-load or mid-run: the cycle is aborted and no further writes occur. The core is left held by test_normal = 1.

## Configuration
- PROG_LOADER_TIMEOUT_EN, defined:
  - A TMO_W-bit counter runs in RUN.
  - At all-ones: timeout = 1, then DONE.
  - cnt of the RUN command is ignored.
- Not defined: RUN waits indefinitely for cpu_halt, and timeout is tied to 0.

## Structure
- Package risc_loader_pkg holds:
  - op encoding constants.
  - State enum typedef.
  - Field-width localparams derived from DW.
- Sub-module risc_out_fifo: parametrised synchronous FIFO (DW, OUT_DEPTH) with registered output, full/empty, and same-cycle push/pop.

## Test plan
- LOAD_DATA base 0x0025, cnt 2, words 0x0047, 0x0089 → data writes (0x25,0x47) then (0x26,0x89) on consecutive cycles. Instruction port stays idle.
- Load 12-word program (LLI/LHI/OUT/LDR/ADD/SUB/HLT) at base 0, then RUN → FIFO yields 0x6325, 0x0047, 0x0089, 0x00D0, 0xFFBE. run_done = 1, test_normal back to 1.
- LOAD_INSTR base 0xFFFF, cnt 2 → writes to 0xFFFF then 0x0000 (wrap). Also LOAD with cnt 0 consumes exactly 2 words and makes no writes.
- OUT_DEPTH = 8, nine OUTs with out_ready = 0 → first 8 retained in order, ovf = 1. A ninth OUT with a pop in the same cycle is accepted.
- With PROG_LOADER_TIMEOUT_EN, TMO_W = 4, core never halts → timeout = 1 exactly 15 cycles after RUN entry, run_done = 0. Without the macro, busy stays 1.
- clr_n asserted mid-LOAD (after word 3 of 5) → we drops immediately, state IDLE, test_normal = 1. A fresh LOAD after release works normally.
